tetris_soc_key_ctrl: RTL and testbench
======================================

Name: tetris_soc_key_ctrl

Overview:
Key input controller for the tetris SoC that sits between the raw active-low pushbutton pins and the Nios II Avalon-MM fabric. It synchronises and debounces NUM_KEYS buttons and sequences per-key press events, including optional held-key auto-repeat for piece movement. Events are latched into an edge-capture register, with a maskable level interrupt to the CPU. Software reads debounced levels and events through a 4-word register window.

Parameters:
NUM_KEYS, 4, number of key inputs (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples required to accept a new level (>=2)
REPEAT_DELAY, 12500000, cycles a key must stay pressed after its press event before the first repeat event
REPEAT_PERIOD, 5000000, cycles between subsequent repeat events while held

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
in_port  input  NUM_KEYS  raw key pins, active-low (0 = pressed), asynchronous to clk
address  input  2  Avalon-MM word address
read  input  1  Avalon-MM read strobe
write  input  1  Avalon-MM write strobe
writedata  input  32  Avalon-MM write data
readdata  output  32  Avalon-MM read data, registered
irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset (async, active-high):
  - sync flops = all 1; debounced level = released; all counters = 0.
  - repeat FSMs = IDLE; irqmask = 0; edgecapture = 0; repeat_en = 0; readdata = 0; irq = 0.
- Synchroniser: 2-flop per bit. pressed_s[i] = ~sync2[i].
- Debounce, per key:
  - Counter clears whenever pressed_s[i] equals level[i].
  - Otherwise the counter increments. On the cycle it reaches DEBOUNCE_CYCLES-1, level[i] toggles and the counter clears.
  - Worst-case latency from pin edge to level change = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level.
- Press event: level[i] rising (released->pressed) sets event[i] for one cycle. Releases generate no event.
- Edge-capture:
  - event[i] sets edgecapture[i].
  - A write to address 2 clears bits where writedata[i]=1.
  - Same-cycle set and clear: set wins and the bit stays 1.
- Registers (address: read / write):
  - 0: {0, level} / ignored
  - 1: {0, irqmask} / irqmask <= writedata[NUM_KEYS-1:0]
  - 2: {0, edgecapture} / write-1-to-clear
  - 3: {0, repeat_en} / repeat_en <= writedata[NUM_KEYS-1:0] (reads 0 and write ignored when the feature is out)
  - Bits above NUM_KEYS read 0.
- readdata:
  - Registered every cycle from the address mux (read is not required). Data is valid the cycle after address is presented: read latency 1.
  - Register writes become visible on the next address-mux sample: write in cycle N, readdata reflects it at N+2.
- irq: registered; irq <= |(edgecapture & irqmask). It asserts 1 cycle after the bit sets and deasserts 1 cycle after the clear.
- Reset mid-debounce or mid-repeat aborts immediately. No event is emitted for a key still held after reset until its debounce completes again.

Optional Feature:
- Macro: TETRIS_KEY_AUTOREPEAT_EN.
- When defined, a per-key repeat FSM is built:
  - IDLE -> DELAY on press event, with timer=0.
  - DELAY: timer increments; at REPEAT_DELAY-1 emit event[i] and go to REPEAT with timer=0.
  - REPEAT: at REPEAT_PERIOD-1 emit event[i] and clear timer.
  - Any state -> IDLE on level[i] released, or when repeat_en[i]=0 (DELAY/REPEAT only).
  - Clearing repeat_en mid-hold stops repeats next cycle. Setting it mid-hold has no effect until the next press.
- When undefined:
  - No FSMs or timers are synthesised.
  - Only press events occur.
  - Address 3 reads 0 and writes are ignored.

Test Plan:
- Bounce rejection (DEBOUNCE_CYCLES=4): pulse in_port[0] low for 3 cycles, 5 times -> level, edgecapture and irq stay 0.
- Clean press (DEBOUNCE_CYCLES=4, irqmask=0x1): hold in_port[0] low -> level[0]=1 exactly 6 cycles after the pin edge; edgecapture=0x1; irq=1 one cycle later. Write 0x1 to address 2 -> irq=0 within 2 cycles.
- Mask and multi-key (irqmask=0x4): press keys 1 and 2 together -> address 2 reads 0x6; irq=1. Clear 0x4 -> irq=0 while edgecapture=0x2.
- Set/clear collision: write-1-clear to bit 3 in the same cycle as key 3's press event -> edgecapture[3]=1.
- Auto-repeat (macro defined, DEBOUNCE=4, DELAY=20, PERIOD=8, repeat_en=0x1): hold key 0 for 60 cycles after the press event -> events at +0, +20, +28, +36, +44, +52. Release -> no further events. With the macro undefined, same stimulus gives a single event and address 3 reads 0.
- Reset mid-hold: assert reset during the REPEAT state -> all outputs 0 the next sample. Key still held after release of reset -> one press event after 2+DEBOUNCE cycles.

Source files
------------

// File: rtl/tetris_soc_key_ctrl.sv
// tetris_soc_key_ctrl: pushbutton front end for the Nios II fabric.
// Synchronises and debounces active-low keys, turns debounced presses
// (plus optional held-key auto-repeat) into edge-capture events, and raises
// a maskable level interrupt.
//
// Optional feature macro: TETRIS_KEY_AUTOREPEAT_EN (per-key repeat FSMs and
// the repeat_en register at address 3).
//
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active-high
//   in_port    raw key pins, active-low, asynchronous to clk
//   address    Avalon-MM word address (0 level, 1 irqmask, 2 edgecapture, 3 repeat_en)
//   read       Avalon-MM read strobe (readdata is sampled every cycle regardless)
//   write      Avalon-MM write strobe
//   writedata  Avalon-MM write data
//   readdata   registered read data, latency 1
//   irq        registered interrupt, |(edgecapture & irqmask)
module tetris_soc_key_ctrl #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] in_port,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NUM_KEYS-1:0]         sync1, sync2;
    logic [NUM_KEYS-1:0]         pressed_s;
    logic [NUM_KEYS-1:0]         level, level_d;
    logic [NUM_KEYS-1:0][DW-1:0] db_cnt;
    logic [NUM_KEYS-1:0]         irqmask, edgecapture;
    logic [NUM_KEYS-1:0]         press_c, evt_c, clr_c;
    logic [31:0]                 rd_mux_c;

    // Two-flop synchroniser; reset to the released (high) pin level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;

    // Debounce: level flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= '0;
            level_d <= '0;
            db_cnt  <= '0;
        end else begin
            level_d <= level;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (pressed_s[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Press event: debounced level going released -> pressed
    assign press_c = level & ~level_d;

`ifdef TETRIS_KEY_AUTOREPEAT_EN
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_t;

    rp_state_t                   rp_q [NUM_KEYS];
    rp_state_t                   rp_d [NUM_KEYS];
    logic [NUM_KEYS-1:0][TW-1:0] tmr_q, tmr_d;
    logic [NUM_KEYS-1:0]         rpt_c;
    logic [NUM_KEYS-1:0]         repeat_en;

    // Repeat FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) rp_q[i] <= RP_IDLE;
            tmr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) rp_q[i] <= rp_d[i];
            tmr_q <= tmr_d;
        end
    end

    // Repeat FSM next state; only a fresh press arms it, so enabling mid-hold waits for the next press
    always_comb begin
        tmr_d = tmr_q;
        rpt_c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rp_d[i] = rp_q[i];
            case (rp_q[i])
                RP_IDLE: begin
                    if (press_c[i]) begin
                        rp_d[i]  = RP_DELAY;
                        tmr_d[i] = '0;
                    end
                end
                RP_DELAY: begin
                    if (!level[i] || !repeat_en[i]) begin
                        rp_d[i] = RP_IDLE;
                    end else if (tmr_q[i] == TW'(REPEAT_DELAY - 1)) begin
                        rpt_c[i] = 1'b1;
                        rp_d[i]  = RP_REPEAT;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + TW'(1);
                    end
                end
                RP_REPEAT: begin
                    if (!level[i] || !repeat_en[i]) begin
                        rp_d[i] = RP_IDLE;
                    end else if (tmr_q[i] == TW'(REPEAT_PERIOD - 1)) begin
                        rpt_c[i] = 1'b1;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + TW'(1);
                    end
                end
                default: rp_d[i] = RP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         repeat_en <= '0;
        else if (write && address == 2'd3) repeat_en <= writedata[NUM_KEYS-1:0];
    end

    assign evt_c = press_c | rpt_c;

    logic unused_bits;
    assign unused_bits = ^{read, writedata};
`else
    assign evt_c = press_c;

    logic unused_bits;
    assign unused_bits = ^{read, writedata, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // Write-1-to-clear mask; a same-cycle event still sets the bit
    assign clr_c = (write && address == 2'd2) ? writedata[NUM_KEYS-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            if (write && address == 2'd1) irqmask <= writedata[NUM_KEYS-1:0];
            edgecapture <= (edgecapture & ~clr_c) | evt_c;
            irq         <= |(edgecapture & irqmask);
        end
    end

    // Read mux, sampled every cycle
    always_comb begin
        rd_mux_c = '0;
        case (address)
            2'd0: rd_mux_c = 32'(level);
            2'd1: rd_mux_c = 32'(irqmask);
            2'd2: rd_mux_c = 32'(edgecapture);
`ifdef TETRIS_KEY_AUTOREPEAT_EN
            2'd3: rd_mux_c = 32'(repeat_en);
`else
            2'd3: rd_mux_c = '0;
`endif
            default: rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux_c;
    end

endmodule

// File: tb/tb_tetris_soc_key_ctrl.sv
// Self-checking bench for tetris_soc_key_ctrl with short debounce/repeat timing.
module tb_tetris_soc_key_ctrl;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic          clk;
    logic          reset;
    logic [NK-1:0] in_port;
    logic [1:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    int exp_q[$];

    tetris_soc_key_ctrl #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single-cycle register write; ends on the negedge after the write edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
    endtask

    // Read with latency 1
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        d    = readdata;
        read = 1'b0;
    endtask

    task automatic release_all();
        in_port = '1;
        settle(10);
        wr(2'd2, 32'hFFFF_FFFF);
        settle(2);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        address = 2'd2;
        settle(3);
        n_vec++;
        if (readdata !== 32'd0) begin
            n_mis++;
            $display("FAIL reset_readdata: got %h want %h", readdata, 32'd0);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_vec++;
            if (d !== 32'd0) begin
                n_mis++;
                $display("FAIL reset_reg%0d: got %h want %h", a, d, 32'd0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        repeat (5) begin
            in_port[0] = 1'b0;
            settle(3);
            in_port[0] = 1'b1;
            settle(3);
        end
        settle(6);
        rd(2'd0, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_mis++;
            $display("FAIL bounce_level: got %h want %h", d, 32'd0);
        end
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_mis++;
            $display("FAIL bounce_edgecap: got %h want %h", d, 32'd0);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL bounce_irq: got %b want 0", irq);
        end
    endtask

    task automatic test_clean_press();
        logic [31:0] d;
        logic        exp_lvl, exp_irq;
        wr(2'd1, 32'h1);
        address    = 2'd0;
        in_port[0] = 1'b0;
        // level at edge 6, visible on readdata at edge 7; irq two edges after level
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_lvl = (k >= 7);
            exp_irq = (k >= 8);
            n_vec++;
            if (readdata[0] !== exp_lvl) begin
                n_mis++;
                $display("FAIL press_level k=%0d: got %b want %b", k, readdata[0], exp_lvl);
            end
            n_vec++;
            if (irq !== exp_irq) begin
                n_mis++;
                $display("FAIL press_irq k=%0d: got %b want %b", k, irq, exp_irq);
            end
        end
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'h1) begin
            n_mis++;
            $display("FAIL press_edgecap: got %h want %h", d, 32'h1);
        end
        wr(2'd2, 32'h1);
        settle(1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL press_irq_clear: got %b want 0", irq);
        end
        release_all();
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_mis++;
            $display("FAIL release_no_event: got %h want %h", d, 32'd0);
        end
    endtask

    task automatic test_mask_multi();
        logic [31:0] d;
        wr(2'd1, 32'h4);
        in_port[2:1] = 2'b00;
        settle(10);
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'h6) begin
            n_mis++;
            $display("FAIL multi_edgecap: got %h want %h", d, 32'h6);
        end
        n_vec++;
        if (irq !== 1'b1) begin
            n_mis++;
            $display("FAIL multi_irq: got %b want 1", irq);
        end
        wr(2'd2, 32'h4);
        settle(1);
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL multi_irq_masked: got %b want 0", irq);
        end
        rd(2'd2, d);
        n_vec++;
        if (d !== 32'h2) begin
            n_mis++;
            $display("FAIL multi_edgecap_after: got %h want %h", d, 32'h2);
        end
        release_all();
    endtask

    task automatic test_collision();
        logic [31:0] d;
        in_port[3] = 1'b0;
        settle(6);
        // press event is live between edges 6 and 7; clear lands on edge 7
        address   = 2'd2;
        writedata = 32'h8;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
        rd(2'd2, d);
        n_vec++;
        if (d[3] !== 1'b1) begin
            n_mis++;
            $display("FAIL collision_set_wins: got %b want 1", d[3]);
        end
        wr(2'd2, 32'h8);
        rd(2'd2, d);
        n_vec++;
        if (d[3] !== 1'b0) begin
            n_mis++;
            $display("FAIL collision_later_clear: got %b want 0", d[3]);
        end
        release_all();
    endtask

    task automatic test_autorepeat();
        logic [31:0] d;
        int          c0;
        int          e;
        wr(2'd3, 32'h1);
        rd(2'd3, d);
        n_vec++;
`ifdef TETRIS_KEY_AUTOREPEAT_EN
        if (d !== 32'h1) begin
            n_mis++;
            $display("FAIL repeat_en_read: got %h want %h", d, 32'h1);
        end
`else
        if (d !== 32'h0) begin
            n_mis++;
            $display("FAIL repeat_en_read: got %h want %h", d, 32'h0);
        end
`endif
        // Continuous clear of bit 0 turns each event into a one-cycle readdata pulse
        address    = 2'd2;
        writedata  = 32'h1;
        write      = 1'b1;
        in_port[0] = 1'b0;
        c0 = cyc;
        // press event at c0+6, seen on readdata two edges later
        exp_q.push_back(c0 + 8);
`ifdef TETRIS_KEY_AUTOREPEAT_EN
        exp_q.push_back(c0 + 8 + 20);
        exp_q.push_back(c0 + 8 + 28);
        exp_q.push_back(c0 + 8 + 36);
        exp_q.push_back(c0 + 8 + 44);
        exp_q.push_back(c0 + 8 + 52);
`endif
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k == 54) in_port[0] = 1'b1;
            if (readdata[0] === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL repeat_unexpected: event at cycle %0d, none expected", cyc - c0);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e) begin
                        n_mis++;
                        $display("FAIL repeat_timing: got cycle %0d want %0d", cyc - c0, e - c0);
                    end
                end
            end
        end
        write     = 1'b0;
        writedata = '0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL repeat_missing: %0d events not seen, want 0", exp_q.size());
        end
        exp_q.delete();
        release_all();
    endtask

    task automatic test_reset_mid_hold();
        logic [31:0] d;
        logic        exp_ec;
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        in_port[0] = 1'b0;
        address    = 2'd2;
        settle(36);
        n_vec++;
        if (irq !== 1'b1) begin
            n_mis++;
            $display("FAIL hold_irq_before_reset: got %b want 1", irq);
        end
        reset = 1'b1;
        settle(1);
        n_vec++;
        if (readdata !== 32'd0) begin
            n_mis++;
            $display("FAIL midhold_reset_readdata: got %h want %h", readdata, 32'd0);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL midhold_reset_irq: got %b want 0", irq);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_ec = (k >= 8);
            n_vec++;
            if (readdata[0] !== exp_ec) begin
                n_mis++;
                $display("FAIL post_reset_press k=%0d: got %b want %b", k, readdata[0], exp_ec);
            end
        end
        settle(30);
        n_vec++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL post_reset_irq: got %b want 0", irq);
        end
        rd(2'd3, d);
        n_vec++;
        if (d !== 32'd0) begin
            n_mis++;
            $display("FAIL post_reset_repeat_en: got %h want %h", d, 32'd0);
        end
        release_all();
    endtask

    initial begin
        reset     = 1'b1;
        in_port   = '1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        @(negedge clk);
        test_reset();
        test_bounce();
        test_clean_press();
        test_mask_multi();
        test_collision();
        test_autorepeat();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
